trace_lockstep_checker: RTL and testbench

TRACE_LOCKSTEP_CHECKER -- requirements
Module: trace_lockstep_checker

---
 rtl/trace_pkg.sv | 14 +
 rtl/trace_fifo.sv | 67 ++++++
 rtl/trace_lockstep_checker.sv | 172 +++++++++++++++++
 tb/tb_trace_lockstep_checker.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the trace lockstep checker.
//   TRACE_W_DEFAULT : default trace word width
//   trace_state_e   : checker FSM states
package trace_pkg;

  localparam int TRACE_W_DEFAULT = 36;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MISMATCH = 2'd1,
    OVERFLOW = 2'd2
  } trace_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous single-clock FIFO for one trace stream.
// The head word is read from the storage registers. A word written on a
// rising edge is visible at head only after that edge, so there is no
// same-cycle bypass. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise the word is dropped.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   flush           : synchronous empty
//   push, push_data : write request and word
//   pop             : remove head word (ignored when empty)
//   head            : current head word
//   full, empty     : occupancy flags
//   count           : number of stored words
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can take a word when a slot is freed in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/trace_lockstep_checker.sv
// Lockstep trace checker: compares the trace of a reference core (A) with
// an optimised core (B) word by word. Each stream is buffered in its own
// FIFO; while running, both heads are popped together whenever both FIFOs
// hold a word. The comparison is registered, and its result updates the
// match counter or latches the first mismatch.
// Optional feature (macro TRACE_CHECK_MAXSKEW_EN): max_skew output
// tracking the peak occupancy difference between the FIFOs.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   clear             : synchronous flush, back to RUN, keeps match_count
//   a_valid, a_data   : stream A word
//   b_valid, b_data   : stream B word
//   mismatch          : sticky, a compared pair differed
//   overflow          : sticky, word dropped at a full FIFO
//   match_count       : number of equal pairs (wraps)
//   fail_a, fail_b    : pair captured at the first mismatch
//   fail_index        : match_count at the first mismatch
//   max_skew          : (macro only) peak |occ(A) - occ(B)|
//
// state    | meaning
// ---------+--------------------------------------------------
// RUN      | pushing, popping and comparing
// MISMATCH | differing pair seen; frozen until reset/clear
// OVERFLOW | word dropped at a full FIFO; frozen until reset/clear
module trace_lockstep_checker
  import trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TRACE_W = TRACE_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 a_valid,
  input  logic [TRACE_W-1:0]   a_data,
  input  logic                 b_valid,
  input  logic [TRACE_W-1:0]   b_data,
  output logic                 mismatch,
  output logic                 overflow,
  output logic [31:0]          match_count,
  output logic [TRACE_W-1:0]   fail_a,
  output logic [TRACE_W-1:0]   fail_b,
  output logic [31:0]          fail_index
`ifdef TRACE_CHECK_MAXSKEW_EN
  ,
  output logic [$clog2(DEPTH):0] max_skew
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  trace_state_e state;
  trace_state_e state_nxt;

  logic               in_run;
  logic               push_a;
  logic               push_b;
  logic               pop_both;
  logic               a_full, a_empty;
  logic               b_full, b_empty;
  logic [TRACE_W-1:0] a_head, b_head;
  logic [CW-1:0]      a_count, b_count;
  logic               ovf_evt;
  logic               cmp_valid;
  logic [TRACE_W-1:0] cmp_a, cmp_b;
  logic               cmp_diff;

  assign in_run   = (state == RUN);
  // Inputs arriving with clear are discarded along with the FIFO contents.
  assign push_a   = a_valid && in_run && !clear;
  assign push_b   = b_valid && in_run && !clear;
  assign pop_both = in_run && !a_empty && !b_empty;
  // Popping the same FIFO in this cycle frees the slot, so no drop.
  assign ovf_evt  = (push_a && a_full && !pop_both) ||
                    (push_b && b_full && !pop_both);
  assign cmp_diff = cmp_valid && (cmp_a != cmp_b);

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(TRACE_W)) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .push      (push_a),
    .push_data (a_data),
    .pop       (pop_both),
    .head      (a_head),
    .full      (a_full),
    .empty     (a_empty),
    .count     (a_count)
  );

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(TRACE_W)) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (clear),
    .push      (push_b),
    .push_data (b_data),
    .pop       (pop_both),
    .head      (b_head),
    .full      (b_full),
    .empty     (b_empty),
    .count     (b_count)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) state <= RUN;
    else                state <= state_nxt;
  end

  // Mismatch outranks overflow when both happen in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (cmp_diff)     state_nxt = MISMATCH;
        else if (ovf_evt) state_nxt = OVERFLOW;
      end
      default: state_nxt = state;
    endcase
  end

  // A pair popped in the cycle the FSM leaves RUN stays in cmp_* but is
  // never evaluated, so the counters freeze at the terminal transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_valid   <= 1'b0;
      cmp_a       <= '0;
      cmp_b       <= '0;
      mismatch    <= 1'b0;
      overflow    <= 1'b0;
      match_count <= '0;
      fail_a      <= '0;
      fail_b      <= '0;
      fail_index  <= '0;
    end else if (clear) begin
      cmp_valid <= 1'b0;
      mismatch  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      cmp_valid <= pop_both;
      if (pop_both) begin
        cmp_a <= a_head;
        cmp_b <= b_head;
      end
      if (in_run) begin
        if (cmp_valid && !cmp_diff) match_count <= match_count + 32'd1;
        if (cmp_diff) begin
          mismatch   <= 1'b1;
          fail_a     <= cmp_a;
          fail_b     <= cmp_b;
          fail_index <= match_count;
        end
        if (ovf_evt) overflow <= 1'b1;
      end
    end
  end

`ifdef TRACE_CHECK_MAXSKEW_EN
  logic [CW-1:0] skew_now;

  assign skew_now = (a_count >= b_count) ? (a_count - b_count)
                                         : (b_count - a_count);

  always_ff @(posedge clk) begin
    if (reset || clear)                         max_skew <= '0;
    else if (in_run && (skew_now > max_skew))   max_skew <= skew_now;
  end
`else
  logic unused_count;
  assign unused_count = ^{a_count, b_count};
`endif

endmodule

// File: tb/tb_trace_lockstep_checker.sv
// Bench for trace_lockstep_checker: directed scenarios plus randomized
// streams, every cycle compared against a queue-based reference model.
module tb_trace_lockstep_checker;

  localparam int DEPTH = 16;
  localparam int TW    = 36;

  logic          clk = 1'b0;
  logic          reset, clear;
  logic          a_valid, b_valid;
  logic [TW-1:0] a_data, b_data;
  logic          mismatch, overflow;
  logic [31:0]   match_count, fail_index;
  logic [TW-1:0] fail_a, fail_b;
`ifdef TRACE_CHECK_MAXSKEW_EN
  logic [$clog2(DEPTH):0] max_skew;
`endif

  always #5 clk = ~clk;

  trace_lockstep_checker #(.DEPTH(DEPTH), .TRACE_W(TW)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .a_valid     (a_valid),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_data      (b_data),
    .mismatch    (mismatch),
    .overflow    (overflow),
    .match_count (match_count),
    .fail_a      (fail_a),
    .fail_b      (fail_b),
    .fail_index  (fail_index)
`ifdef TRACE_CHECK_MAXSKEW_EN
    ,
    .max_skew    (max_skew)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queues hold stored words; a popped pair is judged
  // one cycle later; terminal condition freezes everything.
  logic [TW-1:0] qa[$];
  logic [TW-1:0] qb[$];
  bit            m_run = 1'b1;
  logic          m_mis = 1'b0, m_ovf = 1'b0;
  logic [31:0]   m_cnt = '0, m_fi = '0;
  logic [TW-1:0] m_fa = '0, m_fb = '0;
  bit            pend_v = 1'b0;
  logic [TW-1:0] pend_a, pend_b;
  int            m_skew = 0;

  task automatic model_cycle();
    int            sa, sb, d;
    bit            np_v, stop, ovf_ev;
    logic [TW-1:0] npa, npb;
    if (reset) begin
      qa.delete(); qb.delete();
      m_run = 1'b1; m_mis = 1'b0; m_ovf = 1'b0; m_cnt = '0;
      m_fa = '0; m_fb = '0; m_fi = '0; pend_v = 1'b0; m_skew = 0;
      return;
    end
    if (clear) begin
      qa.delete(); qb.delete();
      m_run = 1'b1; m_mis = 1'b0; m_ovf = 1'b0; pend_v = 1'b0; m_skew = 0;
      return;
    end
    if (!m_run) begin
      pend_v = 1'b0;
      return;
    end
    sa = qa.size(); sb = qb.size();
    d  = (sa > sb) ? sa - sb : sb - sa;
    if (d > m_skew) m_skew = d;
    np_v = (sa > 0) && (sb > 0);
    npa = '0; npb = '0;
    if (np_v) begin
      npa = qa.pop_front();
      npb = qb.pop_front();
    end
    stop = 1'b0;
    if (pend_v) begin
      if (pend_a == pend_b) m_cnt = m_cnt + 32'd1;
      else begin
        m_mis = 1'b1; m_fa = pend_a; m_fb = pend_b; m_fi = m_cnt; stop = 1'b1;
      end
    end
    ovf_ev = 1'b0;
    if (a_valid) begin
      if (qa.size() < DEPTH) qa.push_back(a_data); else ovf_ev = 1'b1;
    end
    if (b_valid) begin
      if (qb.size() < DEPTH) qb.push_back(b_data); else ovf_ev = 1'b1;
    end
    if (ovf_ev) m_ovf = 1'b1;
    if (stop || ovf_ev) m_run = 1'b0;
    pend_v = np_v; pend_a = npa; pend_b = npb;
  endtask

  task automatic compare_all();
    check_val("mismatch",    64'(mismatch),    64'(m_mis));
    check_val("overflow",    64'(overflow),    64'(m_ovf));
    check_val("match_count", 64'(match_count), 64'(m_cnt));
    check_val("fail_a",      64'(fail_a),      64'(m_fa));
    check_val("fail_b",      64'(fail_b),      64'(m_fb));
    check_val("fail_index",  64'(fail_index),  64'(m_fi));
`ifdef TRACE_CHECK_MAXSKEW_EN
    check_val("max_skew",    64'(max_skew),    64'(m_skew));
`endif
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit av, input logic [TW-1:0] ad,
                       input bit bv, input logic [TW-1:0] bd);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    idle(2);
    reset = 1'b0;
    check_val("rst_mismatch", 64'(mismatch),    64'd0);
    check_val("rst_overflow", 64'(overflow),    64'd0);
    check_val("rst_count",    64'(match_count), 64'd0);
    check_val("rst_fail_a",   64'(fail_a),      64'd0);
    check_val("rst_fail_idx", 64'(fail_index),  64'd0);

    // identical streams, 100 words
    for (int i = 1; i <= 100; i++) drive(1'b1, TW'(i), 1'b1, TW'(i));
    idle(4);
    check_val("ident_count",    64'(match_count), 64'd100);
    check_val("ident_mismatch", 64'(mismatch),    64'd0);
    check_val("ident_overflow", 64'(overflow),    64'd0);

    // B lags A by 10 cycles
    do_reset();
    for (int t = 0; t < 30; t++)
      drive(t < 20, TW'(t + 1), t >= 10, TW'(t - 9));
    idle(4);
    check_val("lag_count",    64'(match_count), 64'd20);
    check_val("lag_mismatch", 64'(mismatch),    64'd0);
    check_val("lag_overflow", 64'(overflow),    64'd0);
`ifdef TRACE_CHECK_MAXSKEW_EN
    check_val("lag_max_skew", 64'(max_skew),    64'd10);
`endif

    // differing 7th word
    do_reset();
    for (int t = 0; t < 10; t++) begin
      logic [TW-1:0] wa, wb;
      wa = TW'(t + 1); wb = TW'(t + 1);
      if (t == 6) begin
        wa = 36'h0_1234_5678;
        wb = 36'h0_1234_5679;
      end
      drive(1'b1, wa, 1'b1, wb);
      if (t == 7) check_val("mis_one_cycle", 64'(mismatch), 64'd0);
      if (t == 8) check_val("mis_two_cycle", 64'(mismatch), 64'd1);
    end
    idle(3);
    check_val("mis_fail_a",   64'(fail_a),      64'h0_1234_5678);
    check_val("mis_fail_b",   64'(fail_b),      64'h0_1234_5679);
    check_val("mis_fail_idx", 64'(fail_index),  64'd6);
    check_val("mis_count",    64'(match_count), 64'd6);

    // clear with inputs present, then 5 equal pairs
    clear = 1'b1;
    drive(1'b1, 36'h0_0000_0AAA, 1'b1, 36'h0_0000_0BBB);
    clear = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, TW'(200 + i), 1'b1, TW'(200 + i));
    idle(4);
    check_val("clr_mismatch", 64'(mismatch),    64'd0);
    check_val("clr_count",    64'(match_count), 64'd11);

    // overflow: 17 pushes into A with B idle
    do_reset();
    for (int t = 0; t < 17; t++) begin
      drive(1'b1, TW'(t + 1), 1'b0, '0);
      if (t == 15) check_val("ovf_at_16", 64'(overflow), 64'd0);
      if (t == 16) check_val("ovf_at_17", 64'(overflow), 64'd1);
    end
    for (int t = 0; t < 3; t++) drive(1'b0, '0, 1'b1, TW'(t + 1));
    idle(2);
    check_val("ovf_count", 64'(match_count), 64'd0);

    // push and pop of a full FIFO in one cycle is not an overflow
    do_reset();
    for (int t = 0; t < 15; t++) drive(1'b1, TW'(t + 1), 1'b0, '0);
    for (int t = 0; t < 10; t++) drive(1'b1, TW'(16 + t), 1'b1, TW'(1 + t));
    for (int t = 0; t < 15; t++) drive(1'b0, '0, 1'b1, TW'(11 + t));
    idle(4);
    check_val("fullpp_overflow", 64'(overflow),    64'd0);
    check_val("fullpp_count",    64'(match_count), 64'd25);

    // reset while both streams hold words and a compare is in flight
    do_reset();
    for (int t = 0; t < 3; t++) drive(1'b1, TW'(t + 1), 1'b0, '0);
    for (int t = 0; t < 3; t++) drive(1'b0, '0, 1'b1, TW'(t + 1));
    reset = 1'b1;
    drive(1'b1, TW'(9), 1'b1, TW'(9));
    reset = 1'b0;
    check_val("midrst_count",    64'(match_count), 64'd0);
    check_val("midrst_mismatch", 64'(mismatch),    64'd0);
    for (int i = 0; i < 2; i++) drive(1'b1, TW'(50 + i), 1'b1, TW'(50 + i));
    idle(4);
    check_val("midrst_after", 64'(match_count), 64'd2);

    // randomized streams
    for (int r = 0; r < 6; r++) begin
      int            pa, pb;
      logic [TW-1:0] sa, sb;
      if (r % 2 == 0) do_reset();
      else begin
        clear = 1'b1; idle(1); clear = 1'b0;
      end
      pa = 35 + 5 * r;
      pb = (r < 3) ? pa : 60;
      sa = TW'(r * 1000 + 1);
      sb = sa;
      for (int c = 0; c < 300; c++) begin
        bit            av, bv;
        logic [TW-1:0] bw;
        av = ($urandom_range(0, 99) < pa);
        bv = ($urandom_range(0, 99) < pb);
        bw = sb;
        if ($urandom_range(0, 399) == 0) bw = bw ^ TW'(1);
        if ($urandom_range(0, 89) == 0) begin
          clear = 1'b1;
          drive(av, sa, bv, bw);
          clear = 1'b0;
          sa = TW'(r * 1000 + 500 + c);
          sb = sa;
        end else begin
          drive(av, sa, bv, bw);
          if (av) sa = sa + TW'(1);
          if (bv) sb = sb + TW'(1);
        end
      end
      idle(4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
